// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and special-case flag codes.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] SPC_NONE = 2'd0;
   localparam logic [1:0] SPC_DIV0 = 2'd1;
   localparam logic [1:0] SPC_OVF  = 2'd2;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign conditioning for the multiply/divide unit: turns both operands into
// magnitudes plus sign bits at accept time, and conditionally negates the
// double-width raw result (two's complement) at the exit step.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic              a_signed,
   input  logic              b_signed,
   output logic [XLEN-1:0]   a_mag,
   output logic [XLEN-1:0]   b_mag,
   output logic              a_neg,
   output logic              b_neg,
   input  logic [2*XLEN-1:0] wide,
   input  logic              negate,
   output logic [2*XLEN-1:0] wide_fixed
);

   // Absolute values of the operands and conditional negation of the result;
   // the most negative value maps onto its own bit pattern as an unsigned magnitude.
   always_comb begin
      a_neg      = a_signed & a[XLEN-1];
      b_neg      = b_signed & b[XLEN-1];
      a_mag      = a_neg ? -a : a;
      b_mag      = b_neg ? -b : b;
      wide_fixed = negate ? -wide : wide;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Multiply is MSB-first shift-add over magnitudes, divide is restoring
// shift-subtract; signs are fixed up on the final step.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in a single
// CALC cycle using a combinational product; division stays iterative.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    count;
   logic [2:0]          op;
   logic [XLEN-1:0]     operand_reg;
   logic [XLEN-1:0]     shift_reg;
   logic [2*XLEN-1:0]   acc;
   logic                negate;
   logic [1:0]          spc;

   logic                accept;
   logic                last_step;
   logic                a_signed;
   logic                b_signed;
   logic [XLEN-1:0]     a_mag;
   logic [XLEN-1:0]     b_mag;
   logic                a_neg;
   logic                b_neg;
   logic                accept_negate;
   logic [1:0]          accept_spc;
   logic [2*XLEN-1:0]   mul_acc;
   logic [XLEN:0]       div_shifted;
   logic                div_ge;
   logic [XLEN:0]       div_rem;
   logic [2*XLEN-1:0]   step_acc;
   logic [XLEN-1:0]     step_shift;
   logic [2*XLEN-1:0]   fix_wide;
   logic [2*XLEN-1:0]   fixed;
   logic [XLEN-1:0]     final_result;

   assign accept = (state == S_IDLE) && start;

`ifdef MULDIV_FAST_MUL_EN
   assign last_step = !op[2] || (count == CNT_W'(XLEN - 1));
`else
   assign last_step = (count == CNT_W'(XLEN - 1));
`endif

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .a          (operand_a),
      .b          (operand_b),
      .a_signed   (a_signed),
      .b_signed   (b_signed),
      .a_mag      (a_mag),
      .b_mag      (b_mag),
      .a_neg      (a_neg),
      .b_neg      (b_neg),
      .wide       (fix_wide),
      .negate     (negate),
      .wide_fixed (fixed)
   );

   // Which operands are treated as signed for the requested operation.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (funct3)
         F3_MULH, F3_DIV, F3_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         F3_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
   end

   // Result-negate flag and divide special cases, decided once at accept.
   always_comb begin
      accept_negate = a_neg ^ b_neg;
      if (funct3 == F3_REM || funct3 == F3_REMU) begin
         accept_negate = a_neg;
      end
      accept_spc = SPC_NONE;
      if (funct3[2]) begin
         if (operand_b == '0) begin
            accept_spc = SPC_DIV0;
         end else if (b_signed && operand_a == INT_MIN && operand_b == '1) begin
            accept_spc = SPC_OVF;
         end
      end
   end

   // One arithmetic step: shift-add for multiply, restoring subtract for divide,
   // where the partial remainder lives in the low XLEN+1 bits of the accumulator.
   always_comb begin
      mul_acc     = (acc << 1) + (shift_reg[XLEN-1] ? {{XLEN{1'b0}}, operand_reg} : '0);
      div_shifted = {acc[XLEN-1:0], shift_reg[XLEN-1]};
      div_ge      = div_shifted >= {1'b0, operand_reg};
      div_rem     = div_ge ? (div_shifted - {1'b0, operand_reg}) : div_shifted;
      step_acc    = op[2] ? {{(XLEN-1){1'b0}}, div_rem} : mul_acc;
      step_shift  = {shift_reg[XLEN-2:0], op[2] & div_ge};
`ifdef MULDIV_FAST_MUL_EN
      if (!op[2]) begin
         step_acc = {{XLEN{1'b0}}, operand_reg} * {{XLEN{1'b0}}, shift_reg};
      end
`endif
   end

   // Pick the raw value to sign-correct and the final word to write back;
   // a zero divisor already leaves the dividend as the remainder, so only
   // the quotient needs substituting for that case.
   always_comb begin
      fix_wide = step_acc;
      if (op == F3_DIV || op == F3_DIVU) begin
         fix_wide = {{XLEN{1'b0}}, step_shift};
      end else if (op == F3_REM || op == F3_REMU) begin
         fix_wide = {{XLEN{1'b0}}, step_acc[XLEN-1:0]};
      end
      final_result = fixed[XLEN-1:0];
      case (op)
         F3_MULH, F3_MULHSU, F3_MULHU: final_result = fixed[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU: begin
            if (spc == SPC_DIV0) begin
               final_result = '1;
            end else if (spc == SPC_OVF) begin
               final_result = INT_MIN;
            end
         end
         F3_REM, F3_REMU: begin
            if (spc == SPC_OVF) begin
               final_result = '0;
            end
         end
         default: ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state;
      busy       = (state != S_IDLE);
      done       = (state == S_DONE);
      case (state)
         S_IDLE: if (start) state_next = S_CALC;
         S_CALC: if (last_step) state_next = S_DONE;
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath registers: latch conditioned operands at accept, step while
   // calculating, and write the corrected result on the final step.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count       <= '0;
         op          <= F3_MUL;
         operand_reg <= '0;
         shift_reg   <= '0;
         acc         <= '0;
         negate      <= 1'b0;
         spc         <= SPC_NONE;
         result      <= '0;
      end else if (accept) begin
         count       <= '0;
         op          <= funct3;
         operand_reg <= funct3[2] ? b_mag : a_mag;
         shift_reg   <= funct3[2] ? a_mag : b_mag;
         acc         <= '0;
         negate      <= accept_negate;
         spc         <= accept_spc;
      end else if (state == S_CALC) begin
         count     <= count + CNT_W'(1);
         acc       <= step_acc;
         shift_reg <= step_shift;
         if (last_step) begin
            result <= final_result;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of directed vectors with
// hand-computed results and latencies, plus in-flight start and mid-run reset.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expect_result;
      string       name;
   } vec_t;

   localparam int NVEC = 20;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          tests;
   int          failures;
   vec_t        vecs[NVEC];
   int          lat;
   int          exp_lat;
   logic [31:0] res;
   logic        seen_done;

   muldiv_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .funct3    (funct3),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
      end
   endtask

   // Drive a one-cycle start request; returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      funct3    = f3;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done, bounded so a stuck DUT still reaches the summary.
   task automatic waitDone(output int cycles, output logic [31:0] value);
      cycles = 0;
      while (done !== 1'b1 && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      value = result;
   endtask

   function automatic int expectedLatency(input logic [2:0] f3);
`ifdef MULDIV_FAST_MUL_EN
      return f3[2] ? 32 : 1;
`else
      return (f3 == 3'b111) ? 32 : 32;
`endif
   endfunction

   initial begin
      tests     = 0;
      failures  = 0;
      reset     = 1'b0;
      start     = 1'b0;
      funct3    = 3'b000;
      operand_a = '0;
      operand_b = '0;

      vecs[0]  = '{F3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3"};
      vecs[1]  = '{F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, "mul_wrap"};
      vecs[2]  = '{F3_MUL,    32'h00000006, 32'h00000007, 32'h0000002A, "mul_6_7"};
      vecs[3]  = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_min_min"};
      vecs[4]  = '{F3_MULH,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, "mulh_m1_1"};
      vecs[5]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"};
      vecs[6]  = '{F3_MULHU,  32'h80000000, 32'h00000002, 32'h00000001, "mulhu_carry"};
      vecs[7]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1_max"};
      vecs[8]  = '{F3_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, "div_m7_2"};
      vecs[9]  = '{F3_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, "rem_m7_2"};
      vecs[10] = '{F3_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2"};
      vecs[11] = '{F3_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, "rem_7_m2"};
      vecs[12] = '{F3_DIVU,   32'd100,      32'd7,        32'd14,       "divu_100_7"};
      vecs[13] = '{F3_REMU,   32'd100,      32'd7,        32'd2,        "remu_100_7"};
      vecs[14] = '{F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, "div_by0"};
      vecs[15] = '{F3_REMU,   32'd5,        32'd0,        32'd5,        "remu_by0"};
      vecs[16] = '{F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0"};
      vecs[17] = '{F3_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "rem_m7_by0"};
      vecs[18] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"};
      vecs[19] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"};

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b);
         checkOutput({"busy_at_accept_", vecs[i].name}, {31'b0, busy}, 32'd1);
         waitDone(lat, res);
         exp_lat = expectedLatency(vecs[i].f3);
         checkOutput({"latency_", vecs[i].name}, lat, exp_lat);
         checkOutput({"result_", vecs[i].name}, res, vecs[i].expect_result);
         @(posedge clk);
         #1;
         checkOutput({"idle_after_", vecs[i].name}, {30'b0, busy, done}, 32'd0);
      end

      // A start request while busy must not disturb the running divide.
      applyStimulus(F3_DIVU, 32'd100, 32'd7);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      funct3    = F3_MUL;
      operand_a = 32'd3;
      operand_b = 32'd9;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(lat, res);
      checkOutput("inflight_latency", lat + 6, 32);
      checkOutput("inflight_result", res, 32'd14);
      @(posedge clk);
      #1;
      checkOutput("inflight_result_held", result, 32'd14);

      // Reset in the middle of a divide discards it without a done pulse.
      applyStimulus(F3_DIVU, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
      checkOutput("midreset_done", {31'b0, done}, 32'd0);
      checkOutput("midreset_result", result, 32'd0);
      @(negedge clk);
      reset     = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen_done = seen_done | done;
      end
      checkOutput("midreset_no_done", {31'b0, seen_done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
